// File: rtl/cordic_vector_if.sv
// Handshake and data bundle for the vectoring CORDIC: request (start plus an X/Y pair) and response (angle plus magnitude).
interface cordic_vector_if;
    logic               start;
    logic signed [15:0] x_in;
    logic signed [15:0] y_in;
    logic               busy;
    logic               done;
    logic signed [15:0] angle_out;
    logic        [16:0] mag_out;

    modport master (
        output start, x_in, y_in,
        input  busy, done, angle_out, mag_out
    );

    modport slave (
        input  start, x_in, y_in,
        output busy, done, angle_out, mag_out
    );
endinterface

// File: rtl/cordic_vector.sv
// Iterative vectoring CORDIC: converts (x, y) into a binary angle (32768 = pi) and a gain-scaled magnitude.
// One micro-rotation per clock, after a quadrant pre-rotation that brings the vector into the right half-plane.
module cordic_vector #(
    parameter int ITER = 15
) (
    input  logic           clock,
    input  logic           reset,
    cordic_vector_if.slave bus_io
);
    typedef enum logic [1:0] {IDLE, LOAD, ROTATE, DONE} state_t;

    state_t             state_q, state_d;
    logic signed [15:0] xin_q, xin_d, yin_q, yin_d;
    logic signed [17:0] x_q, x_d, y_q, y_d;
    logic signed [15:0] z_q, z_d;
    logic        [3:0]  cnt_q, cnt_d;
    logic               zero_q, zero_d;
    logic signed [15:0] angle_q, angle_d;
    logic        [16:0] mag_q, mag_d;

    logic signed [17:0] xin_ext, yin_ext, x_sh, y_sh;
    logic signed [15:0] atan_i;

    function automatic logic signed [15:0] atan_lut(input logic [3:0] i);
        case (i)
            4'd0:    return 16'sd8192;
            4'd1:    return 16'sd4836;
            4'd2:    return 16'sd2555;
            4'd3:    return 16'sd1297;
            4'd4:    return 16'sd651;
            4'd5:    return 16'sd326;
            4'd6:    return 16'sd163;
            4'd7:    return 16'sd81;
            4'd8:    return 16'sd41;
            4'd9:    return 16'sd20;
            4'd10:   return 16'sd10;
            4'd11:   return 16'sd5;
            4'd12:   return 16'sd3;
            4'd13:   return 16'sd1;
            4'd14:   return 16'sd1;
            default: return 16'sd0;
        endcase
    endfunction

    assign xin_ext = {{2{xin_q[15]}}, xin_q};
    assign yin_ext = {{2{yin_q[15]}}, yin_q};
    assign x_sh    = x_q >>> cnt_q;
    assign y_sh    = y_q >>> cnt_q;
    assign atan_i  = atan_lut(cnt_q);

    always_comb begin
        state_d = state_q;
        xin_d   = xin_q;
        yin_d   = yin_q;
        x_d     = x_q;
        y_d     = y_q;
        z_d     = z_q;
        cnt_d   = cnt_q;
        zero_d  = zero_q;
        angle_d = angle_q;
        mag_d   = mag_q;

        unique case (state_q)
            IDLE: begin
                if (bus_io.start) begin
                    xin_d   = bus_io.x_in;
                    yin_d   = bus_io.y_in;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                cnt_d  = '0;
                zero_d = (xin_q == '0) && (yin_q == '0);
                // Left half-plane vectors are turned by +/-90 degrees so the iterations always converge.
                if (!xin_q[15]) begin
                    x_d = xin_ext;
                    y_d = yin_ext;
                    z_d = '0;
                end else if (!yin_q[15]) begin
                    x_d = yin_ext;
                    y_d = -xin_ext;
                    z_d = 16'sd16384;
                end else begin
                    x_d = -yin_ext;
                    y_d = xin_ext;
                    z_d = -16'sd16384;
                end
                state_d = ROTATE;
            end
            ROTATE: begin
                if (cnt_q == 4'(ITER)) begin
                    angle_d = zero_q ? '0 : z_q;
                    mag_d   = zero_q ? '0 : x_q[16:0];
                    state_d = DONE;
                end else begin
                    if (!y_q[17]) begin
                        x_d = x_q + y_sh;
                        y_d = y_q - x_sh;
                        z_d = z_q + atan_i;
                    end else begin
                        x_d = x_q - y_sh;
                        y_d = y_q + x_sh;
                        z_d = z_q - atan_i;
                    end
                    cnt_d = cnt_q + 4'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            xin_q   <= '0;
            yin_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            cnt_q   <= '0;
            zero_q  <= 1'b0;
            angle_q <= '0;
            mag_q   <= '0;
        end else begin
            state_q <= state_d;
            xin_q   <= xin_d;
            yin_q   <= yin_d;
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
            cnt_q   <= cnt_d;
            zero_q  <= zero_d;
            angle_q <= angle_d;
            mag_q   <= mag_d;
        end
    end

    assign bus_io.busy      = (state_q != IDLE);
    assign bus_io.done      = (state_q == DONE);
    assign bus_io.angle_out = angle_q;
    assign bus_io.mag_out   = mag_q;
endmodule

// File: tb/tb_cordic_vector.sv
// Bench for cordic_vector: directed corner vectors plus random vectors checked against real-valued atan2/hypot.
module tb_cordic_vector;
    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    cordic_vector_if bus();
    cordic_vector #(.ITER(15)) dut (.clock(clock), .reset(reset), .bus_io(bus));

    localparam real PI    = 3.14159265358979;
    localparam real KGAIN = 1.6467602581;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input int got, input int exp, input int tol, input bit modw);
        int d;
        d = got - exp;
        if (modw) d = int'($signed(d[15:0]));
        n_chk++;
        if (d > tol || d < -tol) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (tol %0d)", tag, got, exp, tol);
        end
    endtask

    function automatic int ref_ang(input int x, input int y);
        return int'($atan2(real'(y), real'(x)) * 32768.0 / PI);
    endfunction

    function automatic int ref_mag(input int x, input int y);
        return int'($sqrt(real'(x) * real'(x) + real'(y) * real'(y)) * KGAIN);
    endfunction

    // Called at a falling edge; returns at the falling edge after the done pulse.
    // mode 1 re-pulses start with (rx, ry) while the first conversion is in flight.
    task automatic run(input int x, input int y, input int mode, input int rx, input int ry,
                       output int a, output int m);
        int lat;
        bus.x_in  = 16'(x);
        bus.y_in  = 16'(y);
        bus.start = 1'b1;
        @(posedge clock);
        lat = 0;
        @(negedge clock);
        bus.start = 1'b0;
        while (!bus.done && lat < 40) begin
            if (mode == 1 && lat == 5) begin
                bus.x_in  = 16'(rx);
                bus.y_in  = 16'(ry);
                bus.start = 1'b1;
            end else begin
                bus.start = 1'b0;
            end
            @(posedge clock);
            lat++;
            @(negedge clock);
        end
        bus.start = 1'b0;
        chk("latency", lat, 17, 0, 1'b0);
        a = int'(bus.angle_out);
        m = int'(bus.mag_out);
        @(negedge clock);
        chk("done_pulse", int'(bus.done), 0, 0, 1'b0);
        chk("hold_ang", int'(bus.angle_out), a, 0, 1'b0);
    endtask

    initial begin
        int a, m, nd;
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.x_in  = '0;
        bus.y_in  = '0;
        repeat (3) @(negedge clock);
        chk("rst_busy", int'(bus.busy), 0, 0, 1'b0);
        chk("rst_done", int'(bus.done), 0, 0, 1'b0);
        chk("rst_ang", int'(bus.angle_out), 0, 0, 1'b0);
        chk("rst_mag", int'(bus.mag_out), 0, 0, 1'b0);
        reset = 1'b0;

        run(16384, 0, 0, 0, 0, a, m);
        chk("px_ang", a, 0, 2, 1'b1);
        chk("px_mag", m, 26981, 4, 1'b0);
        // Issued right after the previous done pulse: back-to-back acceptance.
        run(0, 16384, 0, 0, 0, a, m);
        chk("py_ang", a, 16384, 2, 1'b1);
        chk("py_mag", m, 26981, 4, 1'b0);
        run(-16384, -16384, 0, 0, 0, a, m);
        chk("q3_ang", a, -24576, 2, 1'b1);
        chk("q3_mag", m, 38156, 6, 1'b0);
        run(-16384, 0, 0, 0, 0, a, m);
        chk("nx_ang", a, -32768, 2, 1'b1);
        run(0, 0, 0, 0, 0, a, m);
        chk("zero_ang", a, 0, 0, 1'b0);
        chk("zero_mag", m, 0, 0, 1'b0);

        run(0, 16384, 1, 16384, 0, a, m);
        chk("busy_ign_ang", a, 16384, 2, 1'b1);
        chk("busy_ign_mag", m, 26981, 4, 1'b0);

        // Abort mid-rotation with reset.
        bus.x_in  = 16'sd12000;
        bus.y_in  = 16'sd5000;
        bus.start = 1'b1;
        @(posedge clock);
        @(negedge clock);
        bus.start = 1'b0;
        repeat (8) @(negedge clock);
        chk("pre_abort_busy", int'(bus.busy), 1, 0, 1'b0);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("abort_busy", int'(bus.busy), 0, 0, 1'b0);
        chk("abort_ang", int'(bus.angle_out), 0, 0, 1'b0);
        chk("abort_mag", int'(bus.mag_out), 0, 0, 1'b0);
        nd = 0;
        repeat (25) begin
            @(negedge clock);
            if (bus.done) nd++;
        end
        chk("abort_nodone", nd, 0, 0, 1'b0);
        run(-16384, -16384, 0, 0, 0, a, m);
        chk("post_abort_ang", a, -24576, 2, 1'b1);
        chk("post_abort_mag", m, 38156, 6, 1'b0);

        // Random vectors of reasonable length, so truncation noise stays small relative to the result.
        for (int k = 0; k < 24; k++) begin
            logic [15:0] r;
            int rx, ry;
            do begin
                r  = 16'($urandom);
                rx = int'($signed(r));
                r  = 16'($urandom);
                ry = int'($signed(r));
            end while ((rx < 8192 && rx > -8192) && (ry < 8192 && ry > -8192));
            run(rx, ry, 0, 0, 0, a, m);
            chk("rnd_ang", a, ref_ang(rx, ry), 10, 1'b1);
            chk("rnd_mag", m, ref_mag(rx, ry), 12, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
